// File: rtl/line_clear_engine.sv
// line_clear_engine
//   Post-lock line-clear stage in front of the VGA display. Takes the settled
//   board after a piece locks and finds the full rows. It blinks those rows
//   through the flash mask, then compacts the board downward. It returns the
//   collapsed board and the number of rows cleared.
//
// Ports
//   i_clk        system/pixel clock (single domain)
//   i_clr        synchronous active-high reset; aborts any operation
//   i_start      one-cycle request, i_board_in valid in the same cycle
//   i_board_in   settled board, bit row*COLS+col, row 0 = top
//   o_busy       high from the cycle after accepted start through DONE
//   o_done       one-cycle pulse, result valid
//   o_board_out  board to display (same bit order)
//   o_flash      per-cell flash mask (same bit order)
//   o_lines      full rows found by the last operation (saturating)
module line_clear_engine #(
  parameter int ROWS         = 20,
  parameter int COLS         = 10,
  parameter int FLASH_CYCLES = 6_250_000,
  parameter int FLASH_PHASES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_clr,
  input  logic                 i_start,
  input  logic [ROWS*COLS-1:0] i_board_in,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [ROWS*COLS-1:0] o_board_out,
  output logic [ROWS*COLS-1:0] o_flash,
  output logic [2:0]           o_lines
);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_FLASH, S_COLLAPSE, S_DONE} state_t;

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(FLASH_CYCLES + 1);
  localparam int PW = $clog2(FLASH_PHASES + 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FLASH_CYCLES - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(FLASH_PHASES - 1);

  // Packed [row][col] matches the flat bit order row*COLS+col exactly.
  state_t                      r_state;
  logic [ROWS-1:0][COLS-1:0]   r_work, r_res, r_board_out, r_flash;
  logic [ROWS-1:0]             r_full;
  logic [2:0]                  r_lines;
  logic                        r_busy, r_done;
  logic [CW-1:0]               r_cnt;
  logic [PW-1:0]               r_phase;
  logic [RW-1:0]               r_src, r_wptr;

  logic [ROWS-1:0]             w_full;
  logic [ROWS-1:0][COLS-1:0]   w_scan_mask, w_full_mask, w_res_nxt;
  logic [RW:0]                 w_cnt;
  logic [2:0]                  w_lines;

  genvar g;
  generate
    for (g = 0; g < ROWS; g++) begin : g_row
      assign w_full[g]      = &r_work[g];
      assign w_scan_mask[g] = {COLS{w_full[g]}};   // mask from the live scan
      assign w_full_mask[g] = {COLS{r_full[g]}};   // mask from latched rows
    end
  endgenerate

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < ROWS; i++) w_cnt = w_cnt + {{RW{1'b0}}, w_full[i]};
    w_lines = (|w_cnt[RW:3]) ? 3'd7 : w_cnt[2:0];
  end

  // Next result row: copy the current source row down to the write pointer
  // unless it is being cleared. Also used on the last collapse cycle so the
  // final write lands in o_board_out on the same edge.
  always_comb begin
    w_res_nxt = r_res;
    if (!r_full[r_src]) w_res_nxt[r_wptr] = r_work[r_src];
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state     <= S_IDLE;
      r_work      <= '0;
      r_res       <= '0;
      r_board_out <= '0;
      r_flash     <= '0;
      r_full      <= '0;
      r_lines     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cnt       <= '0;
      r_phase     <= '0;
      r_src       <= '0;
      r_wptr      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          r_done <= 1'b0;
          if (i_start) begin
            r_work      <= i_board_in;
            r_board_out <= i_board_in;
            r_busy      <= 1'b1;
            r_state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          r_full  <= w_full;
          r_lines <= w_lines;
          if (w_full == '0) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt   <= '0;
            r_phase <= '0;
            r_flash <= w_scan_mask;   // phase 0 is visible on the first FLASH cycle
            r_state <= S_FLASH;
          end
        end
        S_FLASH: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            if (r_phase == PH_LAST) begin
              r_flash <= '0;
              r_res   <= '0;
              r_src   <= ROW_LAST;
              r_wptr  <= ROW_LAST;
              r_state <= S_COLLAPSE;
            end else begin
              r_phase <= r_phase + 1'b1;
              // next phase is even exactly when the current one is odd
              r_flash <= r_phase[0] ? w_full_mask : '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_COLLAPSE: begin
          r_res <= w_res_nxt;
          if (!r_full[r_src]) r_wptr <= r_wptr - 1'b1;
          if (r_src == '0) begin
            r_board_out <= w_res_nxt;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_src <= r_src - 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_board_out = r_board_out;
  assign o_flash     = r_flash;
  assign o_lines     = r_lines;

endmodule

// File: tb/tb_line_clear_engine.sv
// Directed bench for line_clear_engine with FLASH_CYCLES=4, FLASH_PHASES=4.
module tb_line_clear_engine;
  localparam int MAXC = 45;

  logic         clk = 1'b0;
  logic         clr, start;
  logic [199:0] board_in;
  logic         busy, done;
  logic [199:0] board_out, flash;
  logic [2:0]   lines;

  int tests = 0;
  int fails = 0;

  logic [199:0] flash_log [0:MAXC];
  logic [199:0] bout_log  [0:MAXC];
  logic         busy_log  [0:MAXC];
  logic         done_log  [0:MAXC];
  logic [2:0]   lines_log [0:MAXC];
  int           done_cyc, ndone;

  line_clear_engine #(.ROWS(20), .COLS(10), .FLASH_CYCLES(4), .FLASH_PHASES(4)) dut (
    .i_clk(clk), .i_clr(clr), .i_start(start), .i_board_in(board_in),
    .o_busy(busy), .o_done(done), .o_board_out(board_out),
    .o_flash(flash), .o_lines(lines)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [199:0] row(input int r, input logic [9:0] v);
    logic [199:0] x;
    x = '0;
    x[r*10 +: 10] = v;
    return x;
  endfunction

  // Issue a start in cycle 0, then log outputs for cycles 1..MAXC.
  // inj_cyc>0: a second start with alt is raised in cycle inj_cyc.
  // clr_cyc>0: clr is raised in cycle clr_cyc.
  task automatic run_op(input logic [199:0] b, input int inj_cyc,
                        input logic [199:0] alt, input int clr_cyc);
    @(negedge clk);
    start = 1'b1; board_in = b;
    @(posedge clk); #1;
    start = 1'b0; board_in = '0;
    done_cyc = -1; ndone = 0;
    for (int k = 1; k <= MAXC; k++) begin
      @(negedge clk);
      flash_log[k] = flash; bout_log[k] = board_out; busy_log[k] = busy;
      done_log[k] = done; lines_log[k] = lines;
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = k;
      end
      start = (inj_cyc > 0 && k == inj_cyc);
      board_in = (inj_cyc > 0 && k == inj_cyc) ? alt : '0;
      clr = (clr_cyc > 0 && k == clr_cyc);
    end
    start = 1'b0; clr = 1'b0;
  endtask

  logic [199:0] b1, b2, b3, b4, fexp;

  initial begin
    clr = 1'b1; start = 1'b0; board_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 200'(busy), 200'(0));
    chk("rst_done", 200'(done), 200'(0));
    chk("rst_bout", board_out, '0);
    chk("rst_flash", flash, '0);
    chk("rst_lines", 200'(lines), 200'(0));
    clr = 1'b0;

    // Empty rows: one hole in row 19
    b1 = row(19, 10'h3FE);
    run_op(b1, 0, '0, 0);
    chk("e_busy1", 200'(busy_log[1]), 200'(1));
    chk("e_bout1", bout_log[1], b1);
    chk("e_donecyc", 200'(done_cyc), 200'(2));
    chk("e_ndone", 200'(ndone), 200'(1));
    chk("e_lines", 200'(lines_log[2]), 200'(0));
    chk("e_bout", bout_log[2], b1);
    fexp = '0;
    for (int k = 1; k <= MAXC; k++) fexp |= flash_log[k];
    chk("e_flash", fexp, '0);
    chk("e_idle_busy", 200'(busy_log[3]), 200'(0));

    // Single row: row 19 full plus bit 180
    b2 = row(19, 10'h3FF);
    b2[180] = 1'b1;
    run_op(b2, 0, '0, 0);
    for (int k = 1; k <= 40; k++) begin
      fexp = ((k >= 2 && k <= 5) || (k >= 10 && k <= 13)) ? row(19, 10'h3FF) : '0;
      chk($sformatf("s_flash_c%0d", k), flash_log[k], fexp);
    end
    chk("s_donecyc", 200'(done_cyc), 200'(38));
    chk("s_ndone", 200'(ndone), 200'(1));
    chk("s_lines", 200'(lines_log[38]), 200'(1));
    chk("s_bout", bout_log[38], row(19, 10'h001));
    chk("s_bout_pre", bout_log[37], b2);
    chk("s_busy38", 200'(busy_log[38]), 200'(1));
    chk("s_busy39", 200'(busy_log[39]), 200'(0));
    chk("s_hold", bout_log[MAXC], row(19, 10'h001));

    // Tetris
    b3 = row(16, 10'h3FF) | row(17, 10'h3FF) | row(18, 10'h3FF) | row(19, 10'h3FF)
       | row(15, 10'h155);
    run_op(b3, 0, '0, 0);
    chk("t_donecyc", 200'(done_cyc), 200'(38));
    chk("t_lines", 200'(lines_log[38]), 200'(4));
    chk("t_bout", bout_log[38], row(19, 10'h155));

    // Non-contiguous full rows
    b4 = row(17, 10'h3FF) | row(19, 10'h3FF) | row(18, 10'h001) | row(16, 10'h200);
    run_op(b4, 0, '0, 0);
    chk("n_lines", 200'(lines_log[38]), 200'(2));
    chk("n_bout", bout_log[38], row(19, 10'h001) | row(18, 10'h200));

    // Second start during FLASH is ignored
    run_op(b2, 5, b3, 0);
    chk("b_donecyc", 200'(done_cyc), 200'(38));
    chk("b_ndone", 200'(ndone), 200'(1));
    chk("b_lines", 200'(lines_log[38]), 200'(1));
    chk("b_bout", bout_log[38], row(19, 10'h001));

    // clr in cycle 20 (COLLAPSE) aborts the operation
    run_op(b4, 0, '0, 20);
    chk("r_busy", 200'(busy_log[21]), 200'(0));
    chk("r_done", 200'(done_log[21]), 200'(0));
    chk("r_bout", bout_log[21], '0);
    chk("r_flash", flash_log[21], '0);
    chk("r_lines", 200'(lines_log[21]), 200'(0));
    chk("r_ndone", 200'(ndone), 200'(0));

    // Fresh start after abort completes normally
    run_op(b4, 0, '0, 0);
    chk("f_donecyc", 200'(done_cyc), 200'(38));
    chk("f_lines", 200'(lines_log[38]), 200'(2));
    chk("f_bout", bout_log[38], row(19, 10'h001) | row(18, 10'h200));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/line_clear_engine.md
# line_clear_engine

Post-lock line-clear stage that sits directly upstream of the VGA display block. It receives the settled 10×20 board from game logic after a piece locks and detects full rows. It drives a blinking flash mask over those rows for the display's flash path, then compacts the board downward and returns the collapsed board plus the number of lines cleared. Its `board_out` and `flash` outputs feed the display's object-matrix and flash-mask inputs directly.

## Interface
- `ROWS`, default 20: board rows; row 0 is the top row.
- `COLS`, default 10: board columns.
- `FLASH_CYCLES`, default 6_250_000: clock cycles per flash phase (0.25 s at 25 MHz).
- `FLASH_PHASES`, default 4: number of flash phases; must be even and ≥ 2.

Ports:
- `clk`  in  1: 25 MHz pixel/system clock. One clock domain only.
- `clr`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle request; `board_in` is valid in the same cycle.
- `board_in`  in  200: settled board; bit `row*10+col`, 1 = occupied.
- `busy`  out  1: high from the cycle after an accepted `start` through the DONE cycle.
- `done`  out  1: one-cycle pulse when the result is valid.
- `board_out`  out  200: board to display, same bit order as `board_in`.
- `flash`  out  200: per-cell flash mask, same bit order.
- `lines`  out  3: full rows found in the last operation, 0–4.

## Operation
- State machine states: IDLE, SCAN, FLASH, COLLAPSE, DONE.
- **IDLE:** `busy`=0.
  - On `start`=1: latch `board_in` into the work register, load `board_out` <= `board_in`, go to SCAN.
- **SCAN (1 cycle):** register `full[19:0]`, where `full[r]` = AND of row r's 10 bits.
  - `lines` <= popcount(`full`), saturated to 3 bits.
  - If `full`==0, go to DONE. Otherwise go to FLASH.
- **FLASH (FLASH_CYCLES*FLASH_PHASES cycles):**
  - A phase counter advances every FLASH_CYCLES cycles.
  - Even phases (0, 2, …): `flash` = `full` expanded to all 10 cells of each full row. Odd phases: `flash` = 0.
  - Phase 0 starts on the first FLASH cycle. After the last phase, go to COLLAPSE.
- **COLLAPSE (exactly ROWS = 20 cycles):**
  - On entry, the result register is 0 and write pointer w = 19.
  - Source row r steps 19, 18, …, 0, one row per cycle.
  - If `full[r]`=0: result row w <= work row r, then w <= w-1. If `full[r]`=1: no write.
  - Rows above the final w remain 0.
  - `flash`=0 throughout.
  - On the edge leaving COLLAPSE: `board_out` <= result.
- **DONE (1 cycle):** `done`=1, `busy`=1. Go to IDLE.
- `start` while `busy`=1 is ignored; no queuing.
- `board_in` is not sampled except on the accepted `start` cycle.
- `board_out` and `lines` hold their values in IDLE until the next accepted `start`. `lines` updates at SCAN.
- Non-contiguous full rows (e.g. rows 17 and 19) collapse correctly; relative order of surviving rows is preserved.

## Timing
- Let cycle 0 be the cycle with `start`=1 in IDLE.
  - Cycle 1: SCAN. `board_out` = `board_in` and `busy` = 1.
  - No full rows: DONE in cycle 2, so `done` is high 2 cycles after `start`, and `board_out` is unchanged.
  - With full rows:
    - FLASH occupies cycles 2 .. P+1, where P = FLASH_CYCLES*FLASH_PHASES.
    - COLLAPSE occupies cycles P+2 .. P+21.
    - DONE occurs in cycle P+22, with the collapsed `board_out` visible in the same cycle.
- `flash` is a registered output, and changes on phase boundaries only.
- Reset values: state IDLE, `busy`=0, `done`=0, `board_out`=0, `flash`=0, `lines`=0. Counters and pointers are 0.
- `clr` mid-operation, in any state, aborts on the next edge to the reset values. No `done` is issued for the aborted operation.
- `clr` and `start` high in the same cycle: `clr` wins and the `start` is dropped.

## Test plan
Simulate with FLASH_CYCLES=4, FLASH_PHASES=4 (P=16).
- **Empty rows:** `board_in` with row 19 = 0x3FE (one hole), all other rows empty, `start` pulse.
  - Required: `done` in cycle 2, `lines`=0, `board_out`==`board_in`, `flash` stays 0.
- **Single row:** bottom row full plus bit 180 (row 18, col 0), `start`.
  - Required: `flash` row 19 all ones in cycles 2–5 and 10–13, 0 otherwise.
  - `done` in cycle 38, `lines`=1, `board_out` has only bit 190 set.
- **Tetris:** rows 16–19 full, row 15 = 0x155, `start`.
  - Required: `lines`=4, and row 19 = 0x155 with all other rows 0 at `done`.
- **Non-contiguous:** rows 17 and 19 full, row 18 = 0x001, row 16 = 0x200.
  - Required: `lines`=2, row 19 = 0x001, row 18 = 0x200, all else 0.
- **Busy/ignore:** second `start` with a different `board_in` during FLASH.
  - Required: ignored, result matches the first board, exactly one `done`.
- **Reset:** `clr` asserted in cycle 20, during COLLAPSE.
  - Required: next cycle has all outputs at reset values and no `done`.
  - A fresh `start` afterwards completes normally.
